// File: rtl/mips_main_control_fsm_if.sv
// ----------------------------------------------------------------------------
// mips_main_control_fsm_if
// Bundle between the multi-cycle MIPS main control FSM and the datapath.
//
// Signals:
//   Op        opcode field from the instruction register (IR[31:26])
//   Zero      ALU zero flag
//   IorD      memory address select: 0 = PC, 1 = ALUOut
//   MemWrite  memory write enable
//   IRWrite   instruction register load
//   RegDst    register write address: 0 = rt, 1 = rd
//   MemtoReg  register write data: 0 = ALUOut, 1 = Data
//   RegWrite  register file write enable
//   ALUSrcA   ALU A: 0 = PC, 1 = A
//   ALUSrcB   ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   ALUOp     to ALU control decoder: 00 add, 01 subtract, 10 use Funct
//   PCSrc     PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
//   PCEn      PC load enable
//
// Modports:
//   master  the control FSM (drives the control lines, reads Op/Zero)
//   slave   the datapath (drives Op/Zero, reads the control lines)
// ----------------------------------------------------------------------------
interface mips_main_control_fsm_if #(
  parameter int op_width     = 6,
  parameter int alu_op_width = 2
);
  logic [op_width-1:0]     Op;
  logic                    Zero;
  logic                    IorD;
  logic                    MemWrite;
  logic                    IRWrite;
  logic                    RegDst;
  logic                    MemtoReg;
  logic                    RegWrite;
  logic                    ALUSrcA;
  logic [1:0]              ALUSrcB;
  logic [alu_op_width-1:0] ALUOp;
  logic [1:0]              PCSrc;
  logic                    PCEn;

  modport master (
    input  Op, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn
  );

  modport slave (
    output Op, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn
  );
endinterface

// File: rtl/mips_main_control_fsm.sv
// ----------------------------------------------------------------------------
// mips_main_control_fsm
// Multi-cycle MIPS main control unit. A Moore FSM walks each instruction
// through fetch, decode, execute, memory and writeback, driving datapath
// enables/mux selects and the 2-bit ALUOp. PCEn additionally folds in Zero
// for conditional branches.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (forces FETCH, gates all enables)
//   bus    mips_main_control_fsm_if.master (Op/Zero in, control lines out)
//
// Configuration macro:
//   BNE_EN  when defined, opcode 000101 (BNE) is decoded into a BNEEX state
//           that branches when Zero is 0. When undefined, 000101 is illegal.
// ----------------------------------------------------------------------------
module mips_main_control_fsm #(
  parameter int op_width     = 6,
  parameter int alu_op_width = 2,
  parameter int state_width  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  mips_main_control_fsm_if.master        bus
);

  // State encodings; codes 13..15 (12..15 without BNE_EN) are unreachable.
  localparam logic [state_width-1:0] FETCH   = 4'd0;
  localparam logic [state_width-1:0] DECODE  = 4'd1;
  localparam logic [state_width-1:0] MEMADR  = 4'd2;
  localparam logic [state_width-1:0] MEMRD   = 4'd3;
  localparam logic [state_width-1:0] MEMWB   = 4'd4;
  localparam logic [state_width-1:0] MEMWR   = 4'd5;
  localparam logic [state_width-1:0] RTYPEEX = 4'd6;
  localparam logic [state_width-1:0] RTYPEWB = 4'd7;
  localparam logic [state_width-1:0] BEQEX   = 4'd8;
  localparam logic [state_width-1:0] ADDIEX  = 4'd9;
  localparam logic [state_width-1:0] ADDIWB  = 4'd10;
  localparam logic [state_width-1:0] JEX     = 4'd11;
`ifdef BNE_EN
  localparam logic [state_width-1:0] BNEEX   = 4'd12;
`endif

  localparam logic [op_width-1:0] OP_LW    = 6'b100011;
  localparam logic [op_width-1:0] OP_SW    = 6'b101011;
  localparam logic [op_width-1:0] OP_RTYPE = 6'b000000;
  localparam logic [op_width-1:0] OP_BEQ   = 6'b000100;
  localparam logic [op_width-1:0] OP_ADDI  = 6'b001000;
  localparam logic [op_width-1:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [op_width-1:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [alu_op_width-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [alu_op_width-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [alu_op_width-1:0] ALUOP_FUNCT = 2'b10;

  // True for the two opcodes that share the MEMADR address computation.
  function automatic logic is_mem_op(input logic [op_width-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  logic [state_width-1:0]  state_r;
  logic [state_width-1:0]  next_state_s;

  logic                    iord_s;
  logic                    mem_write_s;
  logic                    ir_write_s;
  logic                    reg_dst_s;
  logic                    mem_to_reg_s;
  logic                    reg_write_s;
  logic                    alu_src_a_s;
  logic [1:0]              alu_src_b_s;
  logic [alu_op_width-1:0] alu_op_s;
  logic [1:0]              pc_src_s;
  logic                    pc_write_s;
  logic                    branch_s;
  logic                    branch_ne_s;
  logic                    pc_en_s;

  // State register with asynchronous return to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; Op is only consulted in DECODE and MEMADR.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH: begin
        next_state_s = DECODE;
      end
      DECODE: begin
        if (is_mem_op(bus.Op)) begin
          next_state_s = MEMADR;
        end else if (bus.Op == OP_RTYPE) begin
          next_state_s = RTYPEEX;
        end else if (bus.Op == OP_BEQ) begin
          next_state_s = BEQEX;
        end else if (bus.Op == OP_ADDI) begin
          next_state_s = ADDIEX;
        end else if (bus.Op == OP_J) begin
          next_state_s = JEX;
`ifdef BNE_EN
        end else if (bus.Op == OP_BNE) begin
          next_state_s = BNEEX;
`endif
        end else begin
          // Unsupported opcode: abandon the instruction without any write.
          next_state_s = FETCH;
        end
      end
      MEMADR: begin
        if (bus.Op == OP_LW) begin
          next_state_s = MEMRD;
        end else if (bus.Op == OP_SW) begin
          next_state_s = MEMWR;
        end else begin
          next_state_s = FETCH;
        end
      end
      MEMRD:   next_state_s = MEMWB;
      MEMWB:   next_state_s = FETCH;
      MEMWR:   next_state_s = FETCH;
      RTYPEEX: next_state_s = RTYPEWB;
      RTYPEWB: next_state_s = FETCH;
      BEQEX:   next_state_s = FETCH;
      ADDIEX:  next_state_s = ADDIWB;
      ADDIWB:  next_state_s = FETCH;
      JEX:     next_state_s = FETCH;
`ifdef BNE_EN
      BNEEX:   next_state_s = FETCH;
`endif
      default: next_state_s = FETCH;
    endcase
  end

  // Moore output decode; every signal defaults to 0, unreachable codes keep it.
  always_comb begin
    iord_s       = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = ALUOP_ADD;
    pc_src_s     = 2'b00;
    pc_write_s   = 1'b0;
    branch_s     = 1'b0;
    branch_ne_s  = 1'b0;
    case (state_r)
      FETCH: begin
        alu_src_b_s = 2'b01;
        ir_write_s  = 1'b1;
        pc_write_s  = 1'b1;
      end
      DECODE: begin
        alu_src_b_s = 2'b11;
      end
      MEMADR, ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
      end
      MEMRD: begin
        iord_s = 1'b1;
      end
      MEMWB: begin
        mem_to_reg_s = 1'b1;
        reg_write_s  = 1'b1;
      end
      MEMWR: begin
        iord_s      = 1'b1;
        mem_write_s = 1'b1;
      end
      RTYPEEX: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        reg_dst_s   = 1'b1;
        reg_write_s = 1'b1;
      end
      BEQEX: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALUOP_SUB;
        pc_src_s    = 2'b01;
        branch_s    = 1'b1;
      end
`ifdef BNE_EN
      BNEEX: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = ALUOP_SUB;
        pc_src_s    = 2'b01;
        branch_ne_s = 1'b1;
      end
`endif
      ADDIWB: begin
        reg_write_s = 1'b1;
      end
      JEX: begin
        pc_src_s   = 2'b10;
        pc_write_s = 1'b1;
      end
      default: begin
        iord_s = 1'b0;
      end
    endcase
  end

`ifdef BNE_EN
  assign pc_en_s = pc_write_s | (branch_s & bus.Zero) | (branch_ne_s & ~bus.Zero);
`else
  // branch_ne_s is constant 0 here; it is kept only so both builds share decode.
  assign pc_en_s = pc_write_s | (branch_s & bus.Zero) | (branch_ne_s & 1'b0);
`endif

  // The state is FETCH during reset, so the enables are gated explicitly
  // to keep IRWrite/PCEn from firing while rst_n is low.
  assign bus.IorD     = iord_s;
  assign bus.MemWrite = mem_write_s & rst_n;
  assign bus.IRWrite  = ir_write_s & rst_n;
  assign bus.RegDst   = reg_dst_s;
  assign bus.MemtoReg = mem_to_reg_s;
  assign bus.RegWrite = reg_write_s & rst_n;
  assign bus.ALUSrcA  = alu_src_a_s;
  assign bus.ALUSrcB  = alu_src_b_s;
  assign bus.ALUOp    = alu_op_s;
  assign bus.PCSrc    = pc_src_s;
  assign bus.PCEn     = pc_en_s & rst_n;

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// ----------------------------------------------------------------------------
// tb_mips_main_control_fsm
// Directed bench for mips_main_control_fsm. All control outputs are packed
// into one 14-bit word and compared per cycle with hand-written constants:
//   {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
//    ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], PCEn}
// Outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mips_main_control_fsm;

  localparam logic [13:0] V_RESET  = 14'b0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [13:0] V_FETCH  = 14'b0_0_1_0_0_0_0_01_00_00_1;
  localparam logic [13:0] V_DECODE = 14'b0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [13:0] V_MEMADR = 14'b0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [13:0] V_MEMRD  = 14'b1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [13:0] V_MEMWB  = 14'b0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [13:0] V_MEMWR  = 14'b1_1_0_0_0_0_0_00_00_00_0;
  localparam logic [13:0] V_RTEX   = 14'b0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [13:0] V_RTWB   = 14'b0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [13:0] V_BR_TK  = 14'b0_0_0_0_0_0_1_00_01_01_1;
  localparam logic [13:0] V_BR_NT  = 14'b0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [13:0] V_ADDIEX = 14'b0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [13:0] V_ADDIWB = 14'b0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [13:0] V_JEX    = 14'b0_0_0_0_0_0_0_00_00_10_1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mips_main_control_fsm_if #(.op_width(6), .alu_op_width(2)) bus ();

  mips_main_control_fsm #(
    .op_width    (6),
    .alu_op_width(2),
    .state_width (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [13:0] obs;
  assign obs = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc,
                bus.PCEn};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [13:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock (sample on the falling edge) and compare.
  task automatic step(input string tag, input logic [13:0] exp);
    @(negedge clk);
    check(tag, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    bus.Op   = 6'b100011;
    bus.Zero = 1'b0;

    // Reset: FETCH selects, enables held low, even across a clock edge.
    #2;
    check("reset_async", V_RESET);
    @(negedge clk);
    check("reset_held", V_RESET);
    rst_n = 1'b1;
    #1;

    // LW: 5 cycles.
    check("lw_fetch", V_FETCH);
    step("lw_decode", V_DECODE);
    step("lw_memadr", V_MEMADR);
    step("lw_memrd", V_MEMRD);
    step("lw_memwb", V_MEMWB);
    step("lw_back_fetch", V_FETCH);

    // SW: 4 cycles.
    bus.Op = 6'b101011;
    step("sw_decode", V_DECODE);
    step("sw_memadr", V_MEMADR);
    step("sw_memwr", V_MEMWR);
    step("sw_back_fetch", V_FETCH);

    // RTYPE: 4 cycles; Zero=1 must not leak into PCEn.
    bus.Op   = 6'b000000;
    bus.Zero = 1'b1;
    step("rt_decode", V_DECODE);
    step("rt_ex", V_RTEX);
    step("rt_wb", V_RTWB);
    step("rt_back_fetch", V_FETCH);

    // BEQ taken: 3 cycles.
    bus.Op = 6'b000100;
    step("beq1_decode", V_DECODE);
    step("beq1_ex_taken", V_BR_TK);
    step("beq1_back_fetch", V_FETCH);

    // BEQ not taken; flip Zero inside BEQEX to see PCEn follow it.
    bus.Zero = 1'b0;
    step("beq0_decode", V_DECODE);
    step("beq0_ex_not_taken", V_BR_NT);
    bus.Zero = 1'b1;
    #1;
    check("beq_zero_toggle", V_BR_TK);
    step("beq0_back_fetch", V_FETCH);

    // ADDI: 4 cycles.
    bus.Op   = 6'b001000;
    bus.Zero = 1'b0;
    step("addi_decode", V_DECODE);
    step("addi_ex", V_ADDIEX);
    step("addi_wb", V_ADDIWB);
    step("addi_back_fetch", V_FETCH);

    // J: 3 cycles.
    bus.Op = 6'b000010;
    step("j_decode", V_DECODE);
    step("j_ex", V_JEX);
    step("j_back_fetch", V_FETCH);

    // Illegal opcode: 2 cycles, no writes.
    bus.Op = 6'b111111;
    step("ill_decode", V_DECODE);
    step("ill_back_fetch", V_FETCH);

    // Opcode 000101: BNE when enabled, illegal otherwise.
    bus.Op   = 6'b000101;
    bus.Zero = 1'b0;
`ifdef BNE_EN
    step("bne0_decode", V_DECODE);
    step("bne0_ex_taken", V_BR_TK);
    step("bne0_back_fetch", V_FETCH);
    bus.Zero = 1'b1;
    step("bne1_decode", V_DECODE);
    step("bne1_ex_not_taken", V_BR_NT);
    step("bne1_back_fetch", V_FETCH);
`else
    step("op05_decode", V_DECODE);
    step("op05_back_fetch", V_FETCH);
`endif

    // Reset in the middle of LW (during MEMRD).
    bus.Op   = 6'b100011;
    bus.Zero = 1'b0;
    step("mid_decode", V_DECODE);
    step("mid_memadr", V_MEMADR);
    step("mid_memrd", V_MEMRD);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", V_RESET);
    @(negedge clk);
    check("mid_reset_held", V_RESET);
    rst_n = 1'b1;
    #1;
    check("mid_release_fetch", V_FETCH);
    step("mid_after_decode", V_DECODE);
    step("mid_after_memadr", V_MEMADR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
